mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the 5-stage ARM pipeline. It sits directly downstream of the execute stage and holds the EX/MEM pipeline register. It performs LDR/STR accesses to an external data memory over a variable-latency req/ack handshake, and stalls the front of the pipeline while an access is outstanding. It drives the MEM/WB register consumed by write-back, plus the MEM-stage forwarding value and hazard information.

## Interface
- DATA_BASE, 1024: byte address subtracted from the ALU result before word indexing.
- MEM_ADDR_WIDTH, 16: width of the word address to external memory.

- clk  in  1  pipeline clock; one clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control from EX.
- dest_in  in  `REG_ADDRESS_LEN  destination register from EX.
- alu_res_in, val_Rm_in  in  `REGISTER_LEN  ALU result (address or result) and store data from EX.
- stall  out  1  freeze request to IF/ID/EX registers and PC.
- mem_req, mem_we  out  1  access request and write strobe.
- mem_addr  out  MEM_ADDR_WIDTH  word address.
- mem_wdata  out  `REGISTER_LEN  store data.
- mem_ack  in  1  access complete; for reads, mem_rdata is valid in the same cycle.
- mem_rdata  in  `REGISTER_LEN  load data.
- MEM_wb_value  out  `REGISTER_LEN  forwarding value: alu_res of the MEM-stage instruction.
- wb_en_mem, mem_r_en_mem  out  1  hazard-unit view of the MEM-stage instruction.
- dest_mem  out  `REG_ADDRESS_LEN  hazard-unit view of the MEM-stage instruction.
- wb_en_out, mem_r_en_out  out  1  MEM/WB register outputs.
- dest_out  out  `REG_ADDRESS_LEN  MEM/WB register output.
- alu_res_out, mem_data_out  out  `REGISTER_LEN  MEM/WB register outputs.

## Operation
- **R1 (EX/MEM register).** Holds wb_en, mem_r_en, mem_w_en, dest, alu_res and val_Rm. Loads from the EX inputs on every edge where stall=0 and holds otherwise. MEM_wb_value, wb_en_mem, mem_r_en_mem and dest_mem come directly from R1.
- **mem_op.** mem_op = R1.mem_r_en | R1.mem_w_en. If both enables are set, the access is treated as a read.
- **FSM: IDLE, ACCESS.**
  - IDLE: if mem_op, go to ACCESS; otherwise stay in IDLE.
  - ACCESS: on mem_ack, go to IDLE; otherwise stay in ACCESS.
  - mem_ack seen while in IDLE is ignored.
- **Memory port drive.**
  - mem_req = (state==ACCESS).
  - mem_we = (state==ACCESS) & R1.mem_w_en & ~R1.mem_r_en.
  - mem_addr = (R1.alu_res − DATA_BASE)[MEM_ADDR_WIDTH+1:2]. Arithmetic is modulo 2^32, with no range check and byte offset bits ignored.
  - mem_wdata = R1.val_Rm.
  - mem_addr, mem_we and mem_wdata are stable for the whole ACCESS state.
- **stall.** stall = mem_op & ~(state==ACCESS & mem_ack). The signal is combinational.
- **R2 (MEM/WB register).** Loads on every edge.
  - If stall=1, R2 receives a bubble: wb_en=0, mem_r_en=0; data fields keep their old values.
  - Otherwise R2 loads from R1. mem_data_out takes mem_rdata when the instruction is a read completing this cycle; it holds its old value otherwise.

## Timing
- **Reset.** All R1/R2 fields are 0, state is IDLE, and mem_req, mem_we, stall and all outputs are 0. An outstanding access is abandoned: mem_req is 0 in the cycle after the reset edge, and a late mem_ack is ignored.
- **Non-memory instruction.** Enters R1 at edge t and R2 at edge t+1. The MEM stage adds no stall.
- **Memory instruction.**
  - Enters R1 at edge t; cycle t is IDLE with stall=1.
  - ACCESS begins at edge t+1, with mem_req=1 in cycle t+1.
  - With mem_ack in cycle t+1+k (k≥0), stall=0 in that cycle. R2 loads, R1 takes the next instruction, and state returns to IDLE at edge t+2+k.
  - Minimum occupancy is 2 cycles (1 stall cycle).
- **Back-to-back memory ops.** The second op starts its IDLE cycle immediately after the first op's ack edge. mem_req is deasserted for exactly one cycle between accesses.
- **Stall and flush interaction.** While stall=1, upstream flush and branch effects are the upstream stages' responsibility. R1 is never flushed by this block.

## Structure
- Widths come from the shared Defines.v (`REGISTER_LEN, `REG_ADDRESS_LEN, `ADDRESS_LEN).
- Add `MEM_STATE_IDLE / `MEM_STATE_ACCESS to Defines.v.
- One natural sub-module: `mem_access_fsm` (state register plus the mem_req/stall logic). The R1/R2 registers live in the top module.

## Test plan
- **ALU op.** Reset, then present a non-memory op (wb_en=1, dest=3, alu_res=0x55) with no stall → alu_res_out=0x55, dest_out=3, wb_en_out=1 two edges later.
- **Load, zero-latency ack.** LDR with alu_res=1032 and the memory model acking in the first ACCESS cycle with rdata=0xDEADBEEF → mem_addr=2, mem_we=0, stall high for 1 cycle, mem_data_out=0xDEADBEEF, mem_r_en_out=1.
- **Store, 3-cycle ack.** STR with alu_res=1024 and val_Rm=0x1234, ack delayed by 3 cycles → mem_req high for 4 cycles with mem_we=1, mem_addr=0, mem_wdata=0x1234; stall high for 4 cycles; wb_en_out=0 bubbles during the stall.
- **Back-to-back loads.** Two consecutive LDRs → two distinct accesses, mem_req low for exactly one cycle between them, and R1 holds the second load until the first completes.
- **Reset mid-access.** Assert rst during ACCESS with no ack → next cycle mem_req=0, stall=0, all outputs 0. A subsequent spurious mem_ack produces no R2 load.
- **Spurious ack in IDLE.** mem_ack asserted with no memory op in R1 → no state change and no data captured.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM state encoding and pipeline-register layouts for the MEM stage.
package mem_stage_pkg;

  localparam int REGISTER_LEN    = 32;
  localparam int REG_ADDRESS_LEN = 4;
  localparam int ADDRESS_LEN     = 32;

  typedef enum logic {
    MEM_STATE_IDLE   = 1'b0,
    MEM_STATE_ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                       wb_en;
    logic                       mem_r_en;
    logic                       mem_w_en;
    logic [REG_ADDRESS_LEN-1:0] dest;
    logic [REGISTER_LEN-1:0]    alu_res;
    logic [REGISTER_LEN-1:0]    val_rm;
  } ex_mem_t;

  typedef struct packed {
    logic                       wb_en;
    logic                       mem_r_en;
    logic [REG_ADDRESS_LEN-1:0] dest;
    logic [REGISTER_LEN-1:0]    alu_res;
    logic [REGISTER_LEN-1:0]    mem_data;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_fsm.sv
// IDLE/ACCESS sequencer for the data-memory handshake; produces the access
// window (drives mem_req) and the pipeline stall.
module mem_access_fsm
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic mem_ack,
  output logic access,
  output logic stall
);

  mem_state_e state_q;
  mem_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MEM_STATE_IDLE;
    else     state_q <= state_d;
  end

  // An ack arriving while IDLE is deliberately ignored (late ack after reset).
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      MEM_STATE_IDLE: begin
        if (mem_op) state_d = MEM_STATE_ACCESS;
      end
      MEM_STATE_ACCESS: begin
        access = 1'b1;
        if (mem_ack) state_d = MEM_STATE_IDLE;
      end
      default: state_d = MEM_STATE_IDLE;
    endcase
    stall = mem_op & ~(access & mem_ack);
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage ARM pipeline: EX/MEM register, data-memory
// req/ack access with front-end stall, and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_BASE      = 1024,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en_in,
  input  logic                       mem_r_en_in,
  input  logic                       mem_w_en_in,
  input  logic [REG_ADDRESS_LEN-1:0] dest_in,
  input  logic [REGISTER_LEN-1:0]    alu_res_in,
  input  logic [REGISTER_LEN-1:0]    val_Rm_in,
  output logic                       stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [REGISTER_LEN-1:0]    mem_wdata,
  input  logic                       mem_ack,
  input  logic [REGISTER_LEN-1:0]    mem_rdata,
  output logic [REGISTER_LEN-1:0]    MEM_wb_value,
  output logic                       wb_en_mem,
  output logic                       mem_r_en_mem,
  output logic [REG_ADDRESS_LEN-1:0] dest_mem,
  output logic                       wb_en_out,
  output logic                       mem_r_en_out,
  output logic [REG_ADDRESS_LEN-1:0] dest_out,
  output logic [REGISTER_LEN-1:0]    alu_res_out,
  output logic [REGISTER_LEN-1:0]    mem_data_out
);

  ex_mem_t r1;
  mem_wb_t r2;
  logic    mem_op;
  logic    access;
  logic    rd_done;
  logic [REGISTER_LEN-1:0] offset;
  logic    unused_offset_bits;

  assign mem_op  = r1.mem_r_en | r1.mem_w_en;
  assign rd_done = access & mem_ack & r1.mem_r_en;

  mem_access_fsm u_fsm (
    .clk    (clk),
    .rst    (rst),
    .mem_op (mem_op),
    .mem_ack(mem_ack),
    .access (access),
    .stall  (stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= '0;
    end else if (!stall) begin
      r1.wb_en    <= wb_en_in;
      r1.mem_r_en <= mem_r_en_in;
      r1.mem_w_en <= mem_w_en_in;
      r1.dest     <= dest_in;
      r1.alu_res  <= alu_res_in;
      r1.val_rm   <= val_Rm_in;
    end
  end

  // During a stall a bubble goes to write-back; data fields are left as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2 <= '0;
    end else if (stall) begin
      r2.wb_en    <= 1'b0;
      r2.mem_r_en <= 1'b0;
    end else begin
      r2.wb_en    <= r1.wb_en;
      r2.mem_r_en <= r1.mem_r_en;
      r2.dest     <= r1.dest;
      r2.alu_res  <= r1.alu_res;
      if (rd_done) r2.mem_data <= mem_rdata;
    end
  end

  // Port values are held at zero outside the access window so reset leaves every output 0.
  assign offset             = r1.alu_res - REGISTER_LEN'(DATA_BASE);
  assign unused_offset_bits = ^{offset[1:0], offset[REGISTER_LEN-1:MEM_ADDR_WIDTH+2]};
  assign mem_req            = access;
  assign mem_we             = access & r1.mem_w_en & ~r1.mem_r_en;
  assign mem_addr           = access ? offset[MEM_ADDR_WIDTH+1:2] : '0;
  assign mem_wdata          = access ? r1.val_rm : '0;

  assign MEM_wb_value = r1.alu_res;
  assign wb_en_mem    = r1.wb_en;
  assign mem_r_en_mem = r1.mem_r_en;
  assign dest_mem     = r1.dest;

  assign wb_en_out    = r2.wb_en;
  assign mem_r_en_out = r2.mem_r_en;
  assign dest_out     = r2.dest;
  assign alu_res_out  = r2.alu_res;
  assign mem_data_out = r2.mem_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads/stores
// with varying ack latency, back-to-back loads, reset mid-access, stray acks.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [REG_ADDRESS_LEN-1:0] dest_in;
  logic [REGISTER_LEN-1:0]    alu_res_in, val_Rm_in;
  logic                       stall, mem_req, mem_we, mem_ack;
  logic [15:0]                mem_addr;
  logic [REGISTER_LEN-1:0]    mem_wdata, mem_rdata, MEM_wb_value;
  logic                       wb_en_mem, mem_r_en_mem, wb_en_out, mem_r_en_out;
  logic [REG_ADDRESS_LEN-1:0] dest_mem, dest_out;
  logic [REGISTER_LEN-1:0]    alu_res_out, mem_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_BASE(1024), .MEM_ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .dest_in(dest_in), .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .MEM_wb_value(MEM_wb_value), .wb_en_mem(wb_en_mem), .mem_r_en_mem(mem_r_en_mem),
    .dest_mem(dest_mem), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .dest_out(dest_out), .alu_res_out(alu_res_out), .mem_data_out(mem_data_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic wb, input logic rd, input logic wr,
                        input logic [3:0] dst, input logic [31:0] alu, input logic [31:0] rm);
    wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
    dest_in = dst; alu_res_in = alu; val_Rm_in = rm;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    set_ex(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b exp=0", mem_req); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if ({wb_en_out, alu_res_out, mem_data_out} !== '0) begin bad++; $display("[TB] FAIL reset_r2 got=%b/%h/%h exp=0", wb_en_out, alu_res_out, mem_data_out); end
  endtask

  task automatic test_alu_op();
    set_ex(1, 0, 0, 3, 32'h55, 0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL alu_stall got=%b exp=0", stall); end
    total++; if ({wb_en_mem, dest_mem, MEM_wb_value} !== {1'b1, 4'd3, 32'h55}) begin bad++; $display("[TB] FAIL alu_fwd got=%b/%0d/%h exp=1/3/55", wb_en_mem, dest_mem, MEM_wb_value); end
    tick();
    total++; if ({wb_en_out, mem_r_en_out, dest_out, alu_res_out} !== {1'b1, 1'b0, 4'd3, 32'h55}) begin bad++; $display("[TB] FAIL alu_r2 got=%b/%b/%0d/%h exp=1/0/3/55", wb_en_out, mem_r_en_out, dest_out, alu_res_out); end
  endtask

  task automatic test_load_fast();
    set_ex(1, 1, 0, 5, 32'd1032, 0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0);
    #1;
    total++; if ({stall, mem_req} !== 2'b10) begin bad++; $display("[TB] FAIL ld_idle got=%b%b exp=10", stall, mem_req); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'd2}) begin bad++; $display("[TB] FAIL ld_port got=%b/%b/%0d exp=1/0/2", mem_req, mem_we, mem_addr); end
    total++; if ({stall, wb_en_out} !== 2'b00) begin bad++; $display("[TB] FAIL ld_ack_stall got=%b%b exp=00", stall, wb_en_out); end
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    total++; if (mem_data_out !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL ld_data got=%h exp=deadbeef", mem_data_out); end
    total++; if ({mem_r_en_out, wb_en_out, dest_out, mem_req, stall} !== {1'b1, 1'b1, 4'd5, 1'b0, 1'b0}) begin bad++; $display("[TB] FAIL ld_r2 got=%b/%b/%0d/%b/%b exp=1/1/5/0/0", mem_r_en_out, wb_en_out, dest_out, mem_req, stall); end
  endtask

  task automatic test_store_slow();
    set_ex(0, 0, 1, 0, 32'd1024, 32'h1234);
    tick();
    set_ex(0, 0, 0, 0, 0, 0);
    #1;
    total++; if ({stall, mem_req} !== 2'b10) begin bad++; $display("[TB] FAIL st_idle got=%b%b exp=10", stall, mem_req); end
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_ack = (k == 3); mem_rdata = 32'h0BAD0BAD;
      #1;
      total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'd0, 32'h1234}) begin bad++; $display("[TB] FAIL st_port k=%0d got=%b/%b/%0d/%h exp=1/1/0/1234", k, mem_req, mem_we, mem_addr, mem_wdata); end
      total++; if ({stall, wb_en_out} !== {(k != 3), 1'b0}) begin bad++; $display("[TB] FAIL st_stall k=%0d got=%b%b exp=%b0", k, stall, wb_en_out, (k != 3)); end
    end
    tick();
    mem_ack = 1'b0;
    #1;
    total++; if ({mem_req, mem_we} !== 2'b00) begin bad++; $display("[TB] FAIL st_done got=%b%b exp=00", mem_req, mem_we); end
    total++; if (mem_data_out !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL st_nocapture got=%h exp=deadbeef", mem_data_out); end
  endtask

  task automatic test_back_to_back();
    set_ex(1, 1, 0, 1, 32'd1028, 0);
    tick();
    set_ex(1, 1, 0, 2, 32'd1040, 0);
    #1;
    total++; if ({stall, MEM_wb_value} !== {1'b1, 32'd1028}) begin bad++; $display("[TB] FAIL b2b_a_idle got=%b/%0d exp=1/1028", stall, MEM_wb_value); end
    tick();
    total++; if ({mem_req, mem_addr} !== {1'b1, 16'd1}) begin bad++; $display("[TB] FAIL b2b_a_port got=%b/%0d exp=1/1", mem_req, mem_addr); end
    tick();
    total++; if (MEM_wb_value !== 32'd1028) begin bad++; $display("[TB] FAIL b2b_r1_hold got=%0d exp=1028", MEM_wb_value); end
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_a_ack got=%b exp=0", stall); end
    tick();
    set_ex(0, 0, 0, 0, 0, 0);
    mem_ack = 1'b0;
    #1;
    total++; if ({mem_req, stall, MEM_wb_value} !== {1'b0, 1'b1, 32'd1040}) begin bad++; $display("[TB] FAIL b2b_gap got=%b/%b/%0d exp=0/1/1040", mem_req, stall, MEM_wb_value); end
    total++; if ({mem_data_out, dest_out} !== {32'h11111111, 4'd1}) begin bad++; $display("[TB] FAIL b2b_a_r2 got=%h/%0d exp=11111111/1", mem_data_out, dest_out); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    #1;
    total++; if ({mem_req, mem_addr} !== {1'b1, 16'd4}) begin bad++; $display("[TB] FAIL b2b_b_port got=%b/%0d exp=1/4", mem_req, mem_addr); end
    tick();
    mem_ack = 1'b0;
    #1;
    total++; if ({mem_data_out, dest_out, mem_r_en_out} !== {32'h22222222, 4'd2, 1'b1}) begin bad++; $display("[TB] FAIL b2b_b_r2 got=%h/%0d/%b exp=22222222/2/1", mem_data_out, dest_out, mem_r_en_out); end
  endtask

  task automatic test_reset_mid();
    set_ex(1, 1, 0, 7, 32'd1036, 0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL rm_access got=%b exp=1", mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if ({mem_req, stall, mem_we, mem_addr} !== '0) begin bad++; $display("[TB] FAIL rm_port got=%b/%b/%b/%h exp=0", mem_req, stall, mem_we, mem_addr); end
    total++; if ({wb_en_out, mem_data_out, alu_res_out, MEM_wb_value, dest_mem} !== '0) begin bad++; $display("[TB] FAIL rm_regs got=%b/%h/%h/%h/%0d exp=0", wb_en_out, mem_data_out, alu_res_out, MEM_wb_value, dest_mem); end
    mem_ack = 1'b1; mem_rdata = 32'h99;
    tick();
    mem_ack = 1'b0;
    #1;
    total++; if ({mem_data_out, mem_r_en_out, mem_req} !== {32'h0, 1'b0, 1'b0}) begin bad++; $display("[TB] FAIL rm_late_ack got=%h/%b/%b exp=0/0/0", mem_data_out, mem_r_en_out, mem_req); end
  endtask

  task automatic test_spurious_ack();
    set_ex(1, 0, 0, 9, 32'h77, 0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    #1;
    total++; if ({stall, mem_req} !== 2'b00) begin bad++; $display("[TB] FAIL sp_idle got=%b%b exp=00", stall, mem_req); end
    tick();
    mem_ack = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL sp_state got=%b exp=0", mem_req); end
    total++; if ({mem_data_out, alu_res_out, dest_out} !== {32'h0, 32'h77, 4'd9}) begin bad++; $display("[TB] FAIL sp_r2 got=%h/%h/%0d exp=0/77/9", mem_data_out, alu_res_out, dest_out); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_fast();
    test_store_slow();
    test_back_to_back();
    test_reset_mid();
    test_spurious_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
